// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex digit entry block.
package hex_entry_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } state_t;
endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low pushbutton: 2-flop synchronizer, stability
// counter, and a single-cycle strobe on the debounced press (1->0) edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key into the clk domain; idle level is released (1).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
  // the strobe is registered so it lines up with the level flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/hex_entry.sv
// Operator hex entry: digits shift in on ENTER, COMMIT presents the word to a
// downstream consumer over valid/ready, held until accepted.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIBBLE_W-1:0]          nibble_in,
  input  logic                         key_enter_n,
  input  logic                         key_commit_n,
  output logic [NIBBLE_W*DIGITS-1:0]   value_out,
  output logic                         value_valid,
  input  logic                         value_ready,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic [NIBBLE_W*DIGITS-1:0]   entry_digits,
  output logic                         busy
);
  localparam int W  = NIBBLE_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic enter_strobe, commit_strobe;
  logic unused_enter_level, unused_commit_level;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .key_n (key_enter_n),
    .level (unused_enter_level),
    .press (enter_strobe)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
    .clk   (clk),
    .reset (reset),
    .key_n (key_commit_n),
    .level (unused_commit_level),
    .press (commit_strobe)
  );

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   value_q, value_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   shifted;
  logic [CW-1:0]  count_inc;

  // Shift-in result and saturating count, shared by the ENTRY paths.
  assign shifted   = (shift_q << NIBBLE_W) | W'(nibble_in);
  assign count_inc = (count_q == CW'(DIGITS)) ? count_q : count_q + CW'(1);

  // Next-state and datapath: an ENTER in the same cycle as COMMIT is applied
  // first so the committed word includes the new digit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (enter_strobe) begin
          shift_d = W'(nibble_in);
          count_d = CW'(1);
          if (commit_strobe) begin
            value_d = W'(nibble_in);
            state_d = HOLD;
          end else begin
            state_d = ENTRY;
          end
        end
      end
      ENTRY: begin
        if (enter_strobe) begin
          shift_d = shifted;
          count_d = count_inc;
        end
        if (commit_strobe) begin
          value_d = enter_strobe ? shifted : shift_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Keys are ignored while the word waits; value_out survives acceptance.
        if (value_ready) begin
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      value_q <= value_d;
    end
  end

  assign value_out    = value_q;
  assign value_valid  = (state_q == HOLD);
  assign busy         = (state_q == HOLD);
  assign digit_count  = count_q;
  assign entry_digits = shift_q;
endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry with a short debounce window.
module tb_hex_entry;
  localparam int D = 4;
  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    nibble_in;
  logic          key_enter_n, key_commit_n;
  logic [W-1:0]  value_out, entry_digits;
  logic          value_valid, value_ready, busy;
  logic [2:0]    digit_count;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the entered digits as a number, how many were keyed,
  // and the word offered downstream.
  logic [W-1:0] m_shift, m_value;
  int           m_count;
  bit           m_valid;

  wire [36:0] obs = {value_out, value_valid, digit_count, entry_digits, busy};

  function automatic logic [36:0] exp_vec();
    return {m_value, m_valid, 3'(m_count), m_shift, m_valid};
  endfunction

  hex_entry #(.DIGITS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .nibble_in    (nibble_in),
    .key_enter_n  (key_enter_n),
    .key_commit_n (key_commit_n),
    .value_out    (value_out),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .digit_count  (digit_count),
    .entry_digits (entry_digits),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_shift = '0; m_value = '0; m_count = 0; m_valid = 0;
  endtask

  // Hold the key(s) long enough for one accepted press, release, let it settle.
  task automatic press(input bit en, input bit cm, input logic [3:0] nib);
    @(negedge clk);
    nibble_in = nib;
    if (en) key_enter_n = 1'b0;
    if (cm) key_commit_n = 1'b0;
    repeat (D + 4) @(negedge clk);
    key_enter_n  = 1'b1;
    key_commit_n = 1'b1;
    repeat (D + 4) @(negedge clk);
    if (!m_valid) begin
      if (en) begin
        m_shift = (m_shift << 4) | W'(nib);
        m_count = (m_count < N) ? m_count + 1 : N;
      end
      if (cm && m_count > 0) begin
        m_value = m_shift;
        m_valid = 1;
      end
    end
  endtask

  task automatic handshake(input int hold_cycles);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL hold_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
    if (m_valid) begin
      m_valid = 0; m_shift = '0; m_count = 0;
    end
    compared++;
    if (obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL handshake: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    compared++;
    if (obs !== 37'h0) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", obs, 37'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL reset_idle_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    press(1, 0, 4'hA); press(1, 0, 4'h1); press(1, 0, 4'h2); press(1, 0, 4'h3);
    press(0, 1, 4'h0);
    compared++;
    if ({value_out, value_valid, busy} !== {16'hA123, 2'b11}) begin
      mismatched++;
      $display("FAIL basic_commit: got %h/%b/%b want a123/1/1", value_out, value_valid, busy);
    end
    handshake(10);
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 5; i++) press(1, 0, 4'(i));
    compared++;
    if (digit_count !== 3'd4) begin
      mismatched++;
      $display("FAIL saturate_count: got %0d want 4", digit_count);
    end
    press(0, 1, 4'h0);
    compared++;
    if (value_out !== 16'h2345 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL saturate_value: got %h want %h", obs, exp_vec());
    end
    handshake(2);
  endtask

  task automatic test_bounce();
    @(negedge clk);
    nibble_in = 4'h9;
    for (int i = 0; i < 6; i++) begin
      key_enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clk);
        compared++;
        if (digit_count !== 3'd0) begin
          mismatched++;
          $display("FAIL bounce_quiet: got %0d want 0", digit_count);
        end
      end
    end
    key_enter_n = 1'b0;
    // Strobe lands 2+D edges after the final edge; the count moves one edge later.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      compared++;
      if (digit_count !== ((k >= D + 3) ? 3'd1 : 3'd0)) begin
        mismatched++;
        $display("FAIL bounce_edge_%0d: got %0d want %0d", k, digit_count, (k >= D + 3) ? 1 : 0);
      end
    end
    key_enter_n = 1'b1;
    repeat (D + 4) @(negedge clk);
    m_shift = 16'h0009; m_count = 1;
    compared++;
    if (obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL bounce_single: got %h want %h", obs, exp_vec());
    end
    press(0, 1, 4'h0);
    handshake(1);
  endtask

  task automatic test_hold();
    press(1, 0, 4'hB); press(1, 0, 4'hE); press(0, 1, 4'h0);
    press(1, 1, 4'h7);
    compared++;
    if (value_out !== 16'h00BE || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL hold_ignore: got %h want %h", obs, exp_vec());
    end
    handshake(0);
    compared++;
    if (digit_count !== 3'd0) begin
      mismatched++;
      $display("FAIL hold_count: got %0d want 0", digit_count);
    end
  endtask

  task automatic test_reset_mid();
    press(1, 0, 4'hC); press(1, 0, 4'h0); press(1, 0, 4'hD);
    compared++;
    if ({entry_digits, digit_count} !== {16'h0C0D, 3'd3}) begin
      mismatched++;
      $display("FAIL mid_setup: got %h/%0d want 0c0d/3", entry_digits, digit_count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compared++;
    if (obs !== 37'h0) begin
      mismatched++;
      $display("FAIL mid_reset: got %h want %h", obs, 37'h0);
    end
    press(0, 1, 4'h0);
    compared++;
    if (value_valid !== 1'b0 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL mid_commit_ignored: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        press(1, 1, 4'($urandom_range(0, 15)));
      end else begin
        int k = $urandom_range(1, 6);
        for (int j = 0; j < k; j++) press(1, 0, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) press(1, 1, 4'($urandom_range(0, 15)));
        else press(0, 1, 4'h0);
      end
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL random_%0d: got %h want %h", it, obs, exp_vec());
      end
      handshake($urandom_range(0, 5));
    end
  endtask

  initial begin
    reset = 1'b1; nibble_in = 4'h0; key_enter_n = 1'b1; key_commit_n = 1'b1;
    value_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_saturate();
    test_bounce();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
